// File: rtl/iobuf_pkg.sv
// Shared definitions for the registered bidirectional I/O bank:
// the direction-turnaround FSM state type and the width helper for the
// counter that the FSM shares across all of its states.
package iobuf_pkg;

    // Direction-turnaround FSM states. HIZ is the reset state.
    typedef enum logic [1:0] {
        HIZ      = 2'd0,
        TURN_ON  = 2'd1,
        DRIVE    = 2'd2,
        TURN_OFF = 2'd3
    } iobuf_state_e;

    // Width of the shared counter: it must hold TURN_CYCLES (the longest
    // turnaround count) and SYNC_STAGES (the HIZ flush saturation point).
    function automatic int iobuf_cnt_width(input int turn_cycles, input int sync_stages);
        int top;
        top = (turn_cycles > sync_stages) ? turn_cycles : sync_stages;
        if (top < 1) begin
            return 1;
        end
        return $clog2(top + 1);
    endfunction

endpackage

// File: rtl/iobuf_sync.sv
// Multi-stage input synchronizer for the pad bank: STAGES flops in series,
// each WIDTH bits wide, cleared to 0 by the asynchronous active-low reset.
// The output is the last stage of the chain.
module iobuf_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            logic [WIDTH-1:0] stage_q;

            if (gi == 0) begin : g_first
                // First stage captures the raw pad value every clock.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        stage_q <= '0;
                    end else begin
                        stage_q <= d;
                    end
                end
            end else begin : g_next
                // Later stages shift the previous stage along the chain.
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        stage_q <= '0;
                    end else begin
                        stage_q <= g_stage[gi-1].stage_q;
                    end
                end
            end
        end
    endgenerate

    assign q = g_stage[STAGES-1].stage_q;

endmodule

// File: rtl/iobuf_bank_reg.sv
// Registered bidirectional I/O bank.
// WIDTH pads share one direction control. The output path is a single
// register (out_q) gated by a registered output enable (oe_q) and by the
// combinational global tri-state override gts. Pad values come back through
// an SYNC_STAGES-deep synchronizer. A turnaround FSM inserts dead cycles on
// every direction change so the bank never drives while the far end may
// still be driving.
// Optional feature: define IOBUF_BANK_CONTENTION_CHK_EN to add a read-back
// contention checker (sticky contention_err, cleared by err_clr). Without
// it contention_err is tied low and err_clr is ignored.
module iobuf_bank_reg
    import iobuf_pkg::*;
#(
    parameter int WIDTH       = 8,
    parameter int TURN_CYCLES = 2,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             gts,
    input  logic             dir_req,
    input  logic [WIDTH-1:0] out_data,
    inout  wire  [WIDTH-1:0] io,
    output logic [WIDTH-1:0] in_data,
    output logic             in_valid,
    output logic             drive_active,
    output logic             busy,
    input  logic             err_clr,
    output logic             contention_err
);

    localparam int CNT_W = iobuf_cnt_width(TURN_CYCLES, SYNC_STAGES);

    // TURN_ON leaves once cnt has reached TURN_CYCLES, so oe_q rises
    // TURN_CYCLES+1 edges after the request is sampled in HIZ.
    localparam logic [CNT_W-1:0] ON_LAST   = CNT_W'(TURN_CYCLES);
    // TURN_OFF spends exactly TURN_CYCLES cycles before returning to HIZ.
    localparam logic [CNT_W-1:0] OFF_LAST  = CNT_W'((TURN_CYCLES > 0) ? TURN_CYCLES - 1 : 0);
    // HIZ flush: cnt saturates at SYNC_STAGES; in_valid is raised on the
    // edge that moves cnt from SYNC_STAGES-1 to SYNC_STAGES.
    localparam logic [CNT_W-1:0] SYNC_FULL = CNT_W'(SYNC_STAGES);
    localparam logic [CNT_W-1:0] SYNC_LAST = CNT_W'(SYNC_STAGES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    iobuf_state_e     state;
    logic [CNT_W-1:0] cnt;
    logic             oe_q;
    logic [WIDTH-1:0] out_q;

    // Pad driver: only the registered enable and the async override matter,
    // so an asynchronous reset releases the pads immediately through oe_q.
    assign io = (oe_q && !gts) ? out_q : {WIDTH{1'bz}};

    // Output data register, loaded every clock regardless of direction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_q <= '0;
        end else begin
            out_q <= out_data;
        end
    end

    // Input synchronizer samples the pads every clock in every state.
    iobuf_sync #(
        .WIDTH  (WIDTH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (io),
        .q     (in_data)
    );

    // Turnaround FSM with registered enable and status outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= HIZ;
            cnt          <= '0;
            oe_q         <= 1'b0;
            in_valid     <= 1'b0;
            drive_active <= 1'b0;
            busy         <= 1'b0;
        end else begin
            case (state)
                HIZ: begin
                    if (dir_req) begin
                        cnt      <= '0;
                        in_valid <= 1'b0;
                        if (TURN_CYCLES == 0) begin
                            state        <= DRIVE;
                            oe_q         <= 1'b1;
                            drive_active <= 1'b1;
                        end else begin
                            state <= TURN_ON;
                            busy  <= 1'b1;
                        end
                    end else begin
                        // Flush the synchronizer before trusting in_data.
                        if (cnt < SYNC_FULL) begin
                            cnt <= cnt + CNT_ONE;
                        end
                        in_valid <= (cnt >= SYNC_LAST);
                    end
                end

                TURN_ON: begin
                    if (!dir_req) begin
                        // Aborted request: back to receiving, flush restarts.
                        state <= HIZ;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else if (cnt == ON_LAST) begin
                        state        <= DRIVE;
                        cnt          <= '0;
                        busy         <= 1'b0;
                        oe_q         <= 1'b1;
                        drive_active <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                DRIVE: begin
                    if (!dir_req) begin
                        // Release the pads on the same edge the drop is seen.
                        oe_q         <= 1'b0;
                        drive_active <= 1'b0;
                        cnt          <= '0;
                        if (TURN_CYCLES == 0) begin
                            state <= HIZ;
                        end else begin
                            state <= TURN_OFF;
                            busy  <= 1'b1;
                        end
                    end
                end

                TURN_OFF: begin
                    // A new drive request cannot cut the turnaround short.
                    if (cnt == OFF_LAST) begin
                        state <= HIZ;
                        cnt   <= '0;
                        busy  <= 1'b0;
                    end else begin
                        cnt <= cnt + CNT_ONE;
                    end
                end

                default: begin
                    state        <= HIZ;
                    cnt          <= '0;
                    oe_q         <= 1'b0;
                    in_valid     <= 1'b0;
                    drive_active <= 1'b0;
                    busy         <= 1'b0;
                end
            endcase
        end
    end

`ifdef IOBUF_BANK_CONTENTION_CHK_EN
    // Consecutive DRIVE cycles with the override released; the read-back is
    // only meaningful once the driven value has crossed the synchronizer.
    localparam int RUN_W = $clog2(SYNC_STAGES + 1) + 1;
    localparam logic [RUN_W-1:0] RUN_FULL = RUN_W'(SYNC_STAGES);
    localparam logic [RUN_W-1:0] RUN_ONE  = RUN_W'(1);

    logic [RUN_W-1:0] run_cnt;
    logic [WIDTH-1:0] dly_q [SYNC_STAGES];
    logic             chk_en;
    logic             err_q;

    assign chk_en = (state == DRIVE) && !gts && (run_cnt >= RUN_FULL);

    // Count how long the bank has been actively driving the pads.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_cnt <= '0;
        end else if ((state == DRIVE) && !gts) begin
            if (run_cnt < RUN_FULL) begin
                run_cnt <= run_cnt + RUN_ONE;
            end
        end else begin
            run_cnt <= '0;
        end
    end

    // Delay line aligning out_q with the synchronizer output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                dly_q[i] <= '0;
            end
        end else begin
            dly_q[0] <= out_q;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                dly_q[i] <= dly_q[i-1];
            end
        end
    end

    // Sticky contention flag; a clear beats a same-cycle detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else if (err_clr) begin
            err_q <= 1'b0;
        end else if (chk_en && (in_data != dly_q[SYNC_STAGES-1])) begin
            err_q <= 1'b1;
        end
    end

    assign contention_err = err_q;
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign contention_err = 1'b0;
`endif

endmodule
